// File: rtl/rr_req_gnt_arbiter.sv
// rr_req_gnt_arbiter: N-channel round-robin request/grant arbiter with registered one-cycle grant latency
// ports: clk, rst_n (async active-low reset), req (per-channel level requests),
//        gnt / gnt_valid / gnt_id (registered one-hot-or-zero grant, its OR and its binary index),
//        starve (sticky per-channel starvation flags), starve_clr (per-channel synchronous clear of starve)
module rr_req_gnt_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int HOLD_MODE = 0,
    parameter int MAX_WAIT  = 8,
    parameter int ID_W      = $clog2(NUM_REQ),
    parameter int CNT_W     = $clog2(MAX_WAIT + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_valid,
    output logic [ID_W-1:0]    gnt_id,
    output logic [NUM_REQ-1:0] starve,
    input  logic [NUM_REQ-1:0] starve_clr
);
    localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_WAIT);
    logic [ID_W-1:0] ptr, win, idx, nxt;
    logic any, keep;
    int s;
    logic [CNT_W-1:0] cnt [NUM_REQ];
    logic [NUM_REQ-1:0] waiting, hit;
    // descending scan so the requester closest to ptr is the last (winning) assignment
    always_comb begin
        win = '0;
        any = 1'b0;
        s = 0;
        idx = '0;
        for (int o = NUM_REQ - 1; o >= 0; o--) begin
            s = int'(ptr) + o;
            idx = ID_W'(s >= NUM_REQ ? s - NUM_REQ : s);
            if (req[idx]) begin
                win = idx;
                any = 1'b1;
            end
        end
    end
    assign nxt = win == ID_W'(NUM_REQ - 1) ? '0 : win + ID_W'(1);
    // in hold mode an owner still requesting freezes grant and pointer
    assign keep = (HOLD_MODE != 0) && |(gnt & req);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt <= '0;
            gnt_valid <= 1'b0;
            gnt_id <= '0;
            ptr <= '0;
        end else if (!keep) begin
            gnt <= any ? NUM_REQ'(1) << win : '0;
            gnt_valid <= any;
            gnt_id <= any ? win : '0;
            if (any) ptr <= nxt;
        end
    end
    assign waiting = req & ~gnt;
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_REQ; i++) hit[i] = waiting[i] && cnt[i] == MAXC - CNT_W'(1);
    end
    // set has priority over clear so a starvation event is never lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
            starve <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) cnt[i] <= !waiting[i] ? '0 : cnt[i] == MAXC ? MAXC : cnt[i] + CNT_W'(1);
            starve <= (starve & ~starve_clr) | hit;
        end
    end
`ifndef SYNTHESIS
    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt))
        else $error("a_onehot: gnt=%b not one-hot-or-zero", gnt);
    a_valid: assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == |gnt)
        else $error("a_valid: gnt_valid=%b gnt=%b", gnt_valid, gnt);
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_chk
        a_past: assert property (@(posedge clk) disable iff (!rst_n) gnt[i] |-> $past(req[i]))
            else $error("a_past: gnt[%0d] without prior req", i);
        // a continuously requesting channel waits at most NUM_REQ arbitrations in pulse mode
        if (HOLD_MODE == 0) begin : g_pulse
            a_fair: assert property (@(posedge clk) disable iff (!rst_n) int'(cnt[i]) <= NUM_REQ)
                else $error("a_fair: channel %0d waited %0d cycles", i, cnt[i]);
        end
    end
`endif
endmodule
